pwm_hwdet: RTL and testbench
============================

# pwm_hwdet

Hardware pulse-width detector for the light-sensor input `pwm_in`. It measures the high and low time of every complete input period in `sysclk` cycles and publishes the results, with a one-cycle strobe, for the embedded system's GPIO/AXI readback path. It sits directly downstream of the top-level `pwm_in` pin and upstream of the Microblaze software that computes duty cycle. A timeout flags a stuck input (DC level) so software never waits on a dead sensor.

## Interface
- `CNT_WIDTH`, 32: width of the count registers.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchronizer. Legal range is 2 or more.
- `TIMEOUT`, 100_000_000: cycles without an edge before the input is declared stuck (1 s at 100 MHz). Must satisfy 1 < TIMEOUT < 2^CNT_WIDTH.

- `sysclk` in 1: 100 MHz system clock. Every flop is clocked on the rising edge.
- `sysreset` in 1: reset, synchronous and active-high.
- `enable` in 1: when high, measurement runs. When low, the detector is held idle.
- `pwm_in` in 1: asynchronous pulse train from the light sensor.
- `high_count` out CNT_WIDTH: high time of the last complete period, in cycles.
- `low_count` out CNT_WIDTH: low time of the last complete period, in cycles.
- `period_valid` out 1: one-cycle strobe when `high_count` and `low_count` update.
- `stuck_high` out 1: sticky flag. The input was held at 1 for TIMEOUT cycles.
- `stuck_low` out 1: sticky flag. The input was held at 0 for TIMEOUT cycles.

## Operation
- **Synchronizer.** `pwm_in` passes through SYNC_STAGES flops to give `s`. A further flop gives `s_d`.
  - Rise = `s & ~s_d`.
  - Fall = `~s & s_d`.
- **State machine.** States are ARM, HIGH, LOW. Reset and `enable` low both force ARM.
- **ARM.** Counters are cleared. The first rise loads `hi_cnt` = 1 and moves to HIGH. Any partial period after reset or enable is discarded.
- **HIGH.** Each cycle with `s` = 1 increments `hi_cnt`. On fall: `lo_cnt` = 1, `hi_stage` = `hi_cnt`, move to LOW.
- **LOW.** Each cycle with `s` = 0 increments `lo_cnt`. On rise:
  - `high_count` = `hi_stage`, `low_count` = `lo_cnt`.
  - `period_valid` = 1 for one cycle.
  - `stuck_high` and `stuck_low` clear.
  - `hi_cnt` = 1, move to HIGH.
- **Counting rule.** For a clean input with H high and L low cycles per period, the outputs are exactly `high_count` = H and `low_count` = L. A 1-cycle pulse or gap is measured as 1.
- **Timeout.**
  - In HIGH, or in ARM with `s` = 1, `hi_cnt` (or an ARM idle counter) reaching TIMEOUT sets `stuck_high` and clears `stuck_low`.
  - In LOW, or in ARM with `s` = 0, reaching TIMEOUT sets `stuck_low` and clears `stuck_high`.
  - After a timeout the state goes to ARM and counters clear.
  - `high_count` and `low_count` hold their last values. No `period_valid` is generated.
- **Overflow.** Counters never reach 2^CNT_WIDTH, because the timeout fires first. No saturation logic is required.
- **`enable` falling.** The state goes to ARM in the next cycle. Outputs and stuck flags hold.
- **`enable` rising.** Measurement resumes from ARM. The stuck/idle counter restarts at 0.

## Timing
- **Reset values.** `high_count` = 0, `low_count` = 0, `period_valid` = 0, `stuck_high` = 0, `stuck_low` = 0. Synchronizer flops = 0. State = ARM.
- **Reset mid-period.** Everything returns to reset values at the next edge. The in-flight period is lost.
- **Edge latency.** Suppose `pwm_in` is first sampled at a new level at edge k.
  - `s` changes after edge k+SYNC_STAGES-1.
  - The edge is detected combinationally in that cycle.
  - State, counters and outputs update at edge k+SYNC_STAGES.
- **First measurement.** With SYNC_STAGES = 2, `period_valid` and the new counts appear 2 cycles after the second sampled rise following ARM.
- **Strobe timing.** `period_valid` is high for exactly one cycle and coincides with the new counts. The counts remain stable until the next strobe.
- **Simultaneous events.**
  - `sysreset` has priority over everything.
  - `enable` low has priority over edges and timeout.
  - An edge in the same cycle that the counter reaches TIMEOUT is treated as an edge; the timeout is not taken.
- **Throughput.** The minimum measurable period is 2 synchronized cycles (H = 1, L = 1). Back-to-back strobes are then 2 cycles apart.

## Test plan
- **Nominal period.** Reset, `enable` = 1, drive `pwm_in` with H = 30, L = 70 repeatedly → first `period_valid` after the second rise; `high_count` = 30, `low_count` = 70; one strobe every 100 cycles.
- **Partial first period.** Assert `enable` mid-high, then run H = 5, L = 3 → the partial pulse is ignored; the first strobe reports 5/3; the minimum case H = 1, L = 1 reports 1/1 with strobes 2 cycles apart.
- **Stuck input.** Set TIMEOUT = 50 and hold `pwm_in` = 1 after one valid 10/10 period → `stuck_high` = 1 after 50 high cycles; counts hold 10/10. A later 10/10 pulse train clears `stuck_high` at the next strobe. Repeat with `pwm_in` = 0 to check `stuck_low`.
- **Reset mid-operation.** Pulse `sysreset` during LOW of a 40/60 train → all outputs are 0 the next cycle; the next valid report is 40/60.
- **Enable toggle.** Drop `enable` for 20 cycles mid-period of a 25/75 train → no strobe while low; outputs hold the prior 25/75; after re-enable, the first full period reports 25/75.
- **Latency check.** Set SYNC_STAGES = 3, apply a single 8/12 period followed by a rise → `period_valid` asserts exactly 3 edges after the closing rise is first sampled.

Source files
------------

// File: rtl/pwm_hwdet.sv
// pwm_hwdet: measures the high and low time of every complete period of the
// asynchronous pwm_in pin in sysclk cycles. It publishes each result with a
// one-cycle strobe and raises sticky flags when the input stops toggling.
module pwm_hwdet #(
  parameter int          CNT_WIDTH   = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 100_000_000
) (
  input  logic                 sysclk,
  input  logic                 sysreset,
  input  logic                 enable,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] high_count,
  output logic [CNT_WIDTH-1:0] low_count,
  output logic                 period_valid,
  output logic                 stuck_high,
  output logic                 stuck_low
);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TO_C  = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic                   s, rise, fall;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CNT_WIDTH-1:0]   lo_cnt_q, lo_cnt_d;
  logic [CNT_WIDTH-1:0]   hi_stage_q, hi_stage_d;
  logic [CNT_WIDTH-1:0]   idle_cnt_q, idle_cnt_d;

  logic [CNT_WIDTH-1:0]   high_count_q, high_count_d;
  logic [CNT_WIDTH-1:0]   low_count_q, low_count_d;
  logic                   period_valid_q, period_valid_d;
  logic                   stuck_high_q, stuck_high_d;
  logic                   stuck_low_q, stuck_low_d;

  // Synchronizer shift and edge detection on the synchronized level.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s       = sync_q[SYNC_STAGES-1];
    s_dly_d = s;
    rise    = s & ~s_dly_q;
    fall    = ~s & s_dly_q;
  end

  // Measurement FSM: next state, counters, published results and stuck flags.
  always_comb begin
    state_d        = state_q;
    hi_cnt_d       = hi_cnt_q;
    lo_cnt_d       = lo_cnt_q;
    hi_stage_d     = hi_stage_q;
    idle_cnt_d     = idle_cnt_q;
    high_count_d   = high_count_q;
    low_count_d    = low_count_q;
    period_valid_d = 1'b0;
    stuck_high_d   = stuck_high_q;
    stuck_low_d    = stuck_low_q;

    if (!enable) begin
      // Held idle; published results and flags keep their values.
      state_d    = ARM;
      hi_cnt_d   = '0;
      lo_cnt_d   = '0;
      hi_stage_d = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        ARM: begin
          // Wait for a rise so the first measured high phase is complete.
          if (rise) begin
            state_d    = HIGH;
            hi_cnt_d   = ONE_C;
            idle_cnt_d = '0;
          end else if (fall) begin
            // Level changed: the fall cycle is the first of the new level.
            idle_cnt_d = ONE_C;
          end else if (idle_cnt_q == TO_C) begin
            stuck_high_d = s;
            stuck_low_d  = ~s;
            idle_cnt_d   = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + ONE_C;
          end
        end
        HIGH: begin
          // An edge wins over a timeout in the same cycle.
          if (fall) begin
            state_d    = LOW;
            lo_cnt_d   = ONE_C;
            hi_stage_d = hi_cnt_q;
          end else if (hi_cnt_q == TO_C) begin
            state_d      = ARM;
            stuck_high_d = 1'b1;
            stuck_low_d  = 1'b0;
            hi_cnt_d     = '0;
            lo_cnt_d     = '0;
            idle_cnt_d   = '0;
          end else begin
            hi_cnt_d = hi_cnt_q + ONE_C;
          end
        end
        LOW: begin
          // The closing rise publishes the period and opens the next one.
          if (rise) begin
            state_d        = HIGH;
            high_count_d   = hi_stage_q;
            low_count_d    = lo_cnt_q;
            period_valid_d = 1'b1;
            stuck_high_d   = 1'b0;
            stuck_low_d    = 1'b0;
            hi_cnt_d       = ONE_C;
            lo_cnt_d       = '0;
          end else if (lo_cnt_q == TO_C) begin
            state_d      = ARM;
            stuck_low_d  = 1'b1;
            stuck_high_d = 1'b0;
            hi_cnt_d     = '0;
            lo_cnt_d     = '0;
            idle_cnt_d   = '0;
          end else begin
            lo_cnt_d = lo_cnt_q + ONE_C;
          end
        end
        default: begin
          state_d = ARM;
        end
      endcase
    end
  end

  // State and data registers; synchronous reset clears everything.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      sync_q         <= '0;
      s_dly_q        <= 1'b0;
      state_q        <= ARM;
      hi_cnt_q       <= '0;
      lo_cnt_q       <= '0;
      hi_stage_q     <= '0;
      idle_cnt_q     <= '0;
      high_count_q   <= '0;
      low_count_q    <= '0;
      period_valid_q <= 1'b0;
      stuck_high_q   <= 1'b0;
      stuck_low_q    <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      s_dly_q        <= s_dly_d;
      state_q        <= state_d;
      hi_cnt_q       <= hi_cnt_d;
      lo_cnt_q       <= lo_cnt_d;
      hi_stage_q     <= hi_stage_d;
      idle_cnt_q     <= idle_cnt_d;
      high_count_q   <= high_count_d;
      low_count_q    <= low_count_d;
      period_valid_q <= period_valid_d;
      stuck_high_q   <= stuck_high_d;
      stuck_low_q    <= stuck_low_d;
    end
  end

  assign high_count   = high_count_q;
  assign low_count    = low_count_q;
  assign period_valid = period_valid_q;
  assign stuck_high   = stuck_high_q;
  assign stuck_low    = stuck_low_q;

endmodule

// File: tb/tb_pwm_hwdet.sv
// Bench for pwm_hwdet: two instances (A: 2-stage sync, timeout 50;
// B: 3-stage sync, timeout 200) share one directed stimulus. A run-length
// model predicts every output each cycle; literal checks pin key results.
module tb_pwm_hwdet;

  localparam int W = 16;

  logic clk = 1'b0;
  logic sysreset, enable, pwm_in;

  logic [W-1:0] hc_a, lc_a, hc_b, lc_b;
  logic         pv_a, sh_a, sl_a, pv_b, sh_b, sl_b;

  logic [W-1:0] act_hc [2];
  logic [W-1:0] act_lc [2];
  logic         act_pv [2];
  logic         act_sh [2];
  logic         act_sl [2];

  assign act_hc[0] = hc_a;
  assign act_lc[0] = lc_a;
  assign act_pv[0] = pv_a;
  assign act_sh[0] = sh_a;
  assign act_sl[0] = sl_a;
  assign act_hc[1] = hc_b;
  assign act_lc[1] = lc_b;
  assign act_pv[1] = pv_b;
  assign act_sh[1] = sh_b;
  assign act_sl[1] = sl_b;

  pwm_hwdet #(.CNT_WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(50)) dut_a (
    .sysclk(clk), .sysreset(sysreset), .enable(enable), .pwm_in(pwm_in),
    .high_count(hc_a), .low_count(lc_a), .period_valid(pv_a),
    .stuck_high(sh_a), .stuck_low(sl_a)
  );

  pwm_hwdet #(.CNT_WIDTH(W), .SYNC_STAGES(3), .TIMEOUT(200)) dut_b (
    .sysclk(clk), .sysreset(sysreset), .enable(enable), .pwm_in(pwm_in),
    .high_count(hc_b), .low_count(lc_b), .period_valid(pv_b),
    .stuck_high(sh_b), .stuck_low(sl_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (run lengths of the delayed input)
  int   SS [2]  = '{2, 3};
  int   TOV [2] = '{50, 200};
  logic [7:0] mpipe [2];
  logic msd [2];
  int   run [2];
  bit   in_hi [2], have_h [2];
  int   h_len [2];
  int   exp_hc [2], exp_lc [2];
  bit   exp_pv [2], exp_sh [2], exp_sl [2];

  task automatic model_step(input int i);
    logic s, rise, edg;
    int prev;
    if (sysreset) begin
      exp_hc[i] = 0; exp_lc[i] = 0; exp_pv[i] = 0; exp_sh[i] = 0; exp_sl[i] = 0;
      mpipe[i] = '0; msd[i] = 1'b0; run[i] = 0;
      in_hi[i] = 0; have_h[i] = 0; h_len[i] = 0;
    end else begin
      s    = mpipe[i][SS[i]-1];
      edg  = (s != msd[i]);
      rise = s & ~msd[i];
      exp_pv[i] = 0;
      if (!enable) begin
        run[i] = 0; in_hi[i] = 0; have_h[i] = 0;
      end else begin
        prev   = run[i];
        run[i] = edg ? 1 : run[i] + 1;
        if (rise) begin
          if (have_h[i]) begin
            exp_hc[i] = h_len[i]; exp_lc[i] = prev; exp_pv[i] = 1;
            exp_sh[i] = 0; exp_sl[i] = 0;
          end
          in_hi[i] = 1; have_h[i] = 0;
        end else if (edg) begin
          if (in_hi[i]) begin
            h_len[i] = prev; have_h[i] = 1;
          end
          in_hi[i] = 0;
        end else if (run[i] == TOV[i] + 1) begin
          exp_sh[i] = s; exp_sl[i] = ~s;
          run[i] = 0; in_hi[i] = 0; have_h[i] = 0;
        end
      end
      msd[i]   = s;
      mpipe[i] = {mpipe[i][6:0], pwm_in};
    end
  endtask

  // Model advance on each edge, then compare after outputs settle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("i%0d.high_count@%0d", i, cyc), int'(act_hc[i]), exp_hc[i]);
      cmp($sformatf("i%0d.low_count@%0d", i, cyc), int'(act_lc[i]), exp_lc[i]);
      cmp($sformatf("i%0d.period_valid@%0d", i, cyc), int'(act_pv[i]), int'(exp_pv[i]));
      cmp($sformatf("i%0d.stuck_high@%0d", i, cyc), int'(act_sh[i]), int'(exp_sh[i]));
      cmp($sformatf("i%0d.stuck_low@%0d", i, cyc), int'(act_sl[i]), int'(exp_sl[i]));
    end
  end

  // ---------------- strobe log for literal expectations
  typedef struct {int cyc; int hc; int lc;} strobe_t;
  strobe_t slog_a[$];
  strobe_t slog_b[$];

  always @(negedge clk) begin
    if (pv_a === 1'b1) slog_a.push_back('{cyc, int'(hc_a), int'(lc_a)});
    if (pv_b === 1'b1) slog_b.push_back('{cyc, int'(hc_b), int'(lc_b)});
  end

  task automatic chk_strobe(input string name, input int inst, input int at,
                            input int h, input int l);
    bit found = 0;
    strobe_t e = '{0, -1, -1};
    if (inst == 0) begin
      foreach (slog_a[k]) if (slog_a[k].cyc == at) begin found = 1; e = slog_a[k]; end
    end else begin
      foreach (slog_b[k]) if (slog_b[k].cyc == at) begin found = 1; e = slog_b[k]; end
    end
    checks++;
    if (!found || e.hc != h || e.lc != l) begin
      errors++;
      $display("FAIL %s i%0d: strobe at cycle %0d present=%0d counts %0d/%0d, want %0d/%0d",
               name, inst, at, found, e.hc, e.lc, h, l);
    end
  endtask

  task automatic chk_none(input string name, input int inst, input int from, input int to);
    int n = 0;
    if (inst == 0) begin
      foreach (slog_a[k]) if (slog_a[k].cyc >= from && slog_a[k].cyc <= to) n++;
    end else begin
      foreach (slog_b[k]) if (slog_b[k].cyc >= from && slog_b[k].cyc <= to) n++;
    end
    cmp($sformatf("%s i%0d strobes in [%0d,%0d]", name, inst, from, to), n, 0);
  endtask

  task automatic chk_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("%s i%0d high_count", name, i), int'(act_hc[i]), 0);
      cmp($sformatf("%s i%0d low_count", name, i), int'(act_lc[i]), 0);
      cmp($sformatf("%s i%0d period_valid", name, i), int'(act_pv[i]), 0);
      cmp($sformatf("%s i%0d stuck_high", name, i), int'(act_sh[i]), 0);
      cmp($sformatf("%s i%0d stuck_low", name, i), int'(act_sl[i]), 0);
    end
  endtask

  // Hold pwm_in at lvl for n sampling edges (called at a negedge).
  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  int rr [6];
  int q [6];
  int en_on, en_off, s1, t1, t4, u_rst, u3, v1, v3, v4, w1;

  initial begin
    sysreset = 1'b1; enable = 1'b0; pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    sysreset = 1'b0; enable = 1'b1;

    // Nominal 30/70 train: first strobe on the second rise, then every 100.
    drive(0, 10);
    for (int k = 0; k < 5; k++) begin
      rr[k] = cyc + 1; drive(1, 30); drive(0, 70);
    end
    chk_none("nom_first", 1, rr[0], rr[1] + 2);
    for (int k = 1; k < 5; k++) chk_strobe("nom", 1, rr[k] + 3, 30, 70);

    // Enable asserted mid-high: partial pulse ignored, then 5/3 and 1/1.
    enable = 1'b0; drive(1, 5);
    enable = 1'b1; en_on = cyc + 1;
    drive(1, 3); drive(0, 3);
    for (int k = 0; k < 3; k++) begin
      rr[k] = cyc + 1; drive(1, 5); drive(0, 3);
    end
    for (int k = 0; k < 5; k++) begin
      q[k] = cyc + 1; drive(1, 1); drive(0, 1);
    end
    q[5] = cyc + 1; drive(1, 1); drive(0, 10);
    chk_none("partial", 0, en_on, rr[1] + 1);
    chk_strobe("part_first", 0, rr[1] + 2, 5, 3);
    chk_strobe("part_first", 1, rr[1] + 3, 5, 3);
    chk_strobe("part_third", 0, q[0] + 2, 5, 3);
    for (int k = 1; k < 6; k++) begin
      chk_strobe("min_1_1", 0, q[k] + 2, 1, 1);
      chk_strobe("min_1_1", 1, q[k] + 3, 1, 1);
    end

    // Stuck high on A after a 10/10 period, then cleared by a 10/10 train.
    drive(1, 10); drive(0, 10);
    s1 = cyc + 1; drive(1, 80);
    chk_strobe("pre_stuck", 0, s1 + 2, 10, 10);
    cmp("stuck_high set", int'(sh_a), 1);
    cmp("stuck_high lo flag", int'(sl_a), 0);
    cmp("stuck_high hold hc", int'(hc_a), 10);
    cmp("stuck_high hold lc", int'(lc_a), 10);
    drive(0, 10); drive(1, 10); drive(0, 10);
    t1 = cyc + 1; drive(1, 10); drive(0, 10);
    chk_strobe("unstick_hi", 0, t1 + 2, 10, 10);
    cmp("stuck_high cleared", int'(sh_a), 0);
    drive(1, 10); drive(0, 70);
    cmp("stuck_low set", int'(sl_a), 1);
    cmp("stuck_low hi flag", int'(sh_a), 0);
    cmp("stuck_low hold hc", int'(hc_a), 10);
    cmp("stuck_low hold lc", int'(lc_a), 10);
    drive(1, 10); drive(0, 10);
    t4 = cyc + 1; drive(1, 10); drive(0, 10);
    chk_strobe("unstick_lo", 0, t4 + 2, 10, 10);
    cmp("stuck_low cleared", int'(sl_a), 0);

    // Reset pulse during the low phase of a 40/60 train.
    drive(1, 40); drive(0, 60); drive(1, 40); drive(0, 30);
    sysreset = 1'b1; u_rst = cyc + 1;
    @(negedge clk);
    chk_zero("midreset");
    sysreset = 1'b0;
    drive(0, 30); drive(1, 40); drive(0, 60);
    u3 = cyc + 1; drive(1, 40); drive(0, 10);
    chk_none("post_reset", 1, u_rst, u3 + 2);
    chk_strobe("post_reset", 1, u3 + 3, 40, 60);

    // Enable dropped for 20 cycles inside a 25/75 train.
    drive(1, 25); drive(0, 75);
    v1 = cyc + 1; drive(1, 25); drive(0, 30);
    chk_strobe("en_pre", 1, v1 + 3, 25, 75);
    enable = 1'b0; en_off = cyc + 1;
    drive(0, 10);
    cmp("en_low hold hc", int'(hc_b), 25);
    cmp("en_low hold lc", int'(lc_b), 75);
    drive(0, 10);
    enable = 1'b1;
    drive(0, 25); drive(1, 25); drive(0, 75);
    v3 = cyc + 1; drive(1, 25); drive(0, 75);
    v4 = cyc + 1; drive(1, 1); drive(0, 20);
    chk_none("en_toggle", 1, en_off, v3 + 2);
    chk_strobe("en_resume", 1, v3 + 3, 25, 75);
    chk_strobe("en_resume2", 1, v4 + 3, 25, 75);

    // Latency: single 8/12 period closed by a rise.
    drive(1, 8); drive(0, 12);
    w1 = cyc + 1; drive(1, 8); drive(0, 20);
    chk_strobe("lat3", 1, w1 + 3, 8, 12);
    chk_none("lat3_early", 1, w1 + 2, w1 + 2);
    chk_strobe("lat2", 0, w1 + 2, 8, 12);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
